// File: rtl/w_ptr_full_ctrl.sv
// Write-domain pointer/status controller for an async FIFO.
// It produces the binary RAM address, the Gray write pointer, and full, almost-full, free, overflow status.
module w_ptr_full_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int OVF_CNT_W  = 8
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   w_q2_r_ptr,
    input  logic [ADDR_WIDTH:0]   w_af_level,
    input  logic                  w_ovf_clr,
    output logic                  w_ack,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_WIDTH:0]   w_free,
    output logic                  w_ovf,
    output logic [OVF_CNT_W-1:0]  w_ovf_cnt
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_WIDTH);

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] used_next;
    logic [PW-1:0] free_next;
    logic          drop;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_ack       = w_inc & ~w_full;
    assign drop        = w_inc & w_full;
    assign w_addr      = w_bin[ADDR_WIDTH-1:0];
    assign w_bin_next  = w_bin + PW'(w_ack);
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
    assign r_bin       = gray2bin(w_q2_r_ptr);
    // Modular difference stays correct across the pointer wrap because the extra MSB disambiguates laps.
    assign used_next   = w_bin_next - r_bin;
    assign free_next   = DEPTH - used_next;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_bin         <= '0;
            w_ptr         <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_free        <= DEPTH;
            w_ovf         <= 1'b0;
            w_ovf_cnt     <= '0;
        end else begin
            w_bin         <= w_bin_next;
            w_ptr         <= w_gray_next;
            w_full        <= (free_next == '0);
            w_free        <= free_next;
            w_almost_full <= (free_next <= w_af_level);
            // A drop coinciding with a clear restarts the count at one rather than losing the event.
            if (drop) begin
                w_ovf <= 1'b1;
                if (w_ovf_clr) begin
                    w_ovf_cnt <= OVF_CNT_W'(1);
                end else if (w_ovf_cnt != '1) begin
                    w_ovf_cnt <= w_ovf_cnt + OVF_CNT_W'(1);
                end
            end else if (w_ovf_clr) begin
                w_ovf     <= 1'b0;
                w_ovf_cnt <= '0;
            end
        end
    end

    // More than DEPTH words in use can only come from a corrupted pointer.
    assert property (@(posedge w_clk) disable iff (!w_rst_n) used_next <= DEPTH);

endmodule

// File: tb/tb_w_ptr_full_ctrl.sv
// Bench for w_ptr_full_ctrl: vector table, hand sequences, randomized traffic vs a word-count model.
module tb_w_ptr_full_ctrl;

    localparam int AW    = 4;
    localparam int CW    = 8;
    localparam int DEPTH = 16;

    logic          w_clk = 1'b0;
    logic          w_rst_n = 1'b0;
    logic          w_inc = 1'b0;
    logic [AW:0]   w_q2_r_ptr = '0;
    logic [AW:0]   w_af_level = '0;
    logic          w_ovf_clr = 1'b0;
    logic          w_ack;
    logic [AW-1:0] w_addr;
    logic [AW:0]   w_ptr;
    logic          w_full;
    logic          w_almost_full;
    logic [AW:0]   w_free;
    logic          w_ovf;
    logic [CW-1:0] w_ovf_cnt;

    w_ptr_full_ctrl #(.ADDR_WIDTH(AW), .OVF_CNT_W(CW)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_inc(w_inc), .w_q2_r_ptr(w_q2_r_ptr),
        .w_af_level(w_af_level), .w_ovf_clr(w_ovf_clr), .w_ack(w_ack), .w_addr(w_addr),
        .w_ptr(w_ptr), .w_full(w_full), .w_almost_full(w_almost_full), .w_free(w_free),
        .w_ovf(w_ovf), .w_ovf_cnt(w_ovf_cnt)
    );

    always #5 w_clk = ~w_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: total accepted writes and status derived from plain counts.
    int m_w, m_free, m_cnt;
    bit m_full, m_af, m_ovf;

    typedef struct {
        int inc; int clr; int ack; int full; int af; int free; int ovf; int cnt;
    } vec_t;
    vec_t tbl[22];

    function automatic logic [AW:0] gray(input int n);
        logic [AW:0] b;
        b = (AW + 1)'(n & 31);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_free = DEPTH; m_full = 0; m_af = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ptr"}, int'(w_ptr), 0);
        chk({tag, "_addr"}, int'(w_addr), 0);
        chk({tag, "_full"}, int'(w_full), 0);
        chk({tag, "_af"}, int'(w_almost_full), 0);
        chk({tag, "_free"}, int'(w_free), DEPTH);
        chk({tag, "_ovf"}, int'(w_ovf), 0);
        chk({tag, "_cnt"}, int'(w_ovf_cnt), 0);
    endtask

    task automatic do_reset(input int af);
        w_rst_n = 1'b0; w_inc = 1'b0; w_ovf_clr = 1'b0; w_q2_r_ptr = '0;
        w_af_level = (AW + 1)'(af);
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        model_reset();
        #1;
        chk_reset_vals("reset");
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic apply(input bit inc, input bit clr, input int rcnt, input int af, output int ack_seen);
        logic [AW:0] prev_ptr;
        int exp_ack, used;
        w_inc = inc; w_ovf_clr = clr; w_q2_r_ptr = gray(rcnt); w_af_level = (AW + 1)'(af);
        #1;
        exp_ack = (inc && !m_full) ? 1 : 0;
        ack_seen = int'(w_ack);
        chk("ack", ack_seen, exp_ack);
        prev_ptr = w_ptr;
        @(posedge w_clk);
        #1;
        m_w += exp_ack;
        used = m_w - rcnt;
        m_free = DEPTH - used;
        m_full = (m_free == 0);
        m_af = (m_free <= af);
        if (inc && !exp_ack) begin
            m_ovf = 1;
            m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        end else if (clr) begin
            m_ovf = 0; m_cnt = 0;
        end
        chk("ptr", int'(w_ptr), int'(gray(m_w)));
        chk("addr", int'(w_addr), m_w % DEPTH);
        chk("full", int'(w_full), int'(m_full));
        chk("free", int'(w_free), m_free);
        chk("almost_full", int'(w_almost_full), int'(m_af));
        chk("ovf", int'(w_ovf), int'(m_ovf));
        chk("ovf_cnt", int'(w_ovf_cnt), m_cnt);
        chk("ptr_step_le1", ($countones(prev_ptr ^ w_ptr) <= 1) ? 1 : 0, 1);
        @(negedge w_clk);
    endtask

    initial begin
        int a;
        int rcnt;
        int af;
        logic [AW:0] full_ptr;
        logic [AW:0] held_ptr;

        for (int i = 0; i < 16; i++)
            tbl[i] = '{1, 0, 1, (i == 15) ? 1 : 0, ((15 - i) <= 4) ? 1 : 0, 15 - i, 0, 0};
        for (int i = 16; i < 19; i++)
            tbl[i] = '{1, 0, 0, 1, 1, 0, 1, i - 15};
        tbl[19] = '{0, 1, 0, 1, 1, 0, 0, 0};
        tbl[20] = '{1, 1, 0, 1, 1, 0, 1, 1};
        tbl[21] = '{0, 0, 0, 1, 1, 0, 1, 1};

        // Table: fill with read pointer held at 0, almost-full at 4, then overflow and clear.
        @(negedge w_clk);
        do_reset(4);
        full_ptr = 5'b11000;
        held_ptr = '0;
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].inc[0], tbl[i].clr[0], 0, 4, a);
            chk($sformatf("tbl%0d_ack", i), a, tbl[i].ack);
            chk($sformatf("tbl%0d_full", i), int'(w_full), tbl[i].full);
            chk($sformatf("tbl%0d_af", i), int'(w_almost_full), tbl[i].af);
            chk($sformatf("tbl%0d_free", i), int'(w_free), tbl[i].free);
            chk($sformatf("tbl%0d_ovf", i), int'(w_ovf), tbl[i].ovf);
            chk($sformatf("tbl%0d_cnt", i), int'(w_ovf_cnt), tbl[i].cnt);
            if (i == 15) begin
                chk("fill_ptr", int'(w_ptr), int'(full_ptr));
                held_ptr = w_ptr;
            end
            if (i == 18) chk("ovf_ptr_held", int'(w_ptr), int'(held_ptr));
        end

        // Threshold 0: almost-full follows full exactly.
        do_reset(0);
        for (int i = 0; i < 17; i++) begin
            apply(1, 0, 0, 0, a);
            chk("af0_tracks_full", int'(w_almost_full), int'(w_full));
        end

        // Threshold at or above DEPTH: almost-full from the first edge.
        do_reset(DEPTH);
        apply(0, 0, 0, DEPTH, a);
        chk("af16_first_edge", int'(w_almost_full), 1);
        do_reset(31);
        apply(0, 0, 0, 31, a);
        chk("af31_first_edge", int'(w_almost_full), 1);

        // Counter saturation under a long run of drops.
        do_reset(4);
        for (int i = 0; i < 16; i++) apply(1, 0, 0, 4, a);
        for (int i = 0; i < 260; i++) apply(1, 0, 0, 4, a);
        chk("ovf_cnt_saturated", int'(w_ovf_cnt), 255);
        apply(1, 1, 0, 4, a);
        chk("drop_beats_clr", int'(w_ovf_cnt), 1);

        // Randomized traffic with reads advancing the Gray pointer one step at a time.
        do_reset(4);
        rcnt = 0;
        af = $urandom_range(0, 20);
        for (int i = 0; i < 400; i++) begin
            if (rcnt < m_w && $urandom_range(0, 1) == 1) rcnt++;
            if (i % 100 == 99) af = $urandom_range(0, 20);
            apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rcnt, af, a);
        end
        chk("random_wrapped", (m_w >= 40) ? 1 : 0, 1);

        // Asynchronous reset mid-burst, observed before any clock edge.
        do_reset(4);
        for (int i = 0; i < 9; i++) apply(1, 0, 0, 4, a);
        chk("pre_async_free", int'(w_free), 7);
        w_inc = 1'b1;
        #2;
        w_rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge w_clk);
        w_rst_n = 1'b1;
        w_inc = 1'b0;
        model_reset();
        apply(1, 0, 0, 4, a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
